// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-subset main controller (FETCH/DECODE/EXE/MEM/WB).
// In: clk, reset(sync low), opcode, funct, zero. Out: datapath enables/selects, state.
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWr,
  output logic       IRWr,
  output logic [1:0] NPCOp,
  output logic       ExtOp,
  output logic       iflui,
  output logic       ALUSrc,
  output logic [2:0] ALUOp,
  output logic       RegWr,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       MemWr,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    FETCH  = 3'b000,
    DECODE = 3'b001,
    EXE    = 3'b010,
    MEM_RD = 3'b011,
    MEM_WR = 3'b100,
    WB     = 3'b101
  } state_t;

  state_t st_q, st_d;

  logic rtype;
  logic is_addu, is_subu, is_jr;
  logic is_ori, is_lw, is_sw, is_beq;
  logic is_lui, is_j, is_jal;

  assign rtype   = (opcode == 6'b000000);
  assign is_addu = rtype && (funct == 6'b100001);
  assign is_subu = rtype && (funct == 6'b100011);
  assign is_jr   = rtype && (funct == 6'b001000);
  assign is_ori  = (opcode == 6'b001101);
  assign is_lw   = (opcode == 6'b100011);
  assign is_sw   = (opcode == 6'b101011);
  assign is_beq  = (opcode == 6'b000100);
  assign is_lui  = (opcode == 6'b001111);
  assign is_j    = (opcode == 6'b000010);
  assign is_jal  = (opcode == 6'b000011);

  // Selects depend only on the instruction, never on state.
  assign ExtOp  = is_lw | is_sw | is_beq;
  assign iflui  = is_lui;
  assign ALUSrc = is_ori | is_lw | is_sw | is_lui;

  always_comb begin
    ALUOp = 3'b000;
    unique case (1'b1)
      is_subu, is_beq: ALUOp = 3'b001;
      is_ori:          ALUOp = 3'b010;
      default:         ALUOp = 3'b000;
    endcase
  end

  always_comb begin
    RegDst = 2'b00;
    unique case (1'b1)
      is_addu, is_subu: RegDst = 2'b01;
      is_jal:           RegDst = 2'b10;
      default:          RegDst = 2'b00;
    endcase
  end

  always_comb begin
    MemtoReg = 2'b00;
    unique case (1'b1)
      is_lw:   MemtoReg = 2'b01;
      is_jal:  MemtoReg = 2'b10;
      default: MemtoReg = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) st_q <= FETCH;
    else        st_q <= st_d;
  end

  assign state = st_q;

  always_comb begin
    st_d  = FETCH;
    PCWr  = 1'b0;
    IRWr  = 1'b0;
    RegWr = 1'b0;
    MemWr = 1'b0;
    NPCOp = 2'b00;
    case (st_q)
      FETCH: begin
        IRWr = 1'b1;
        PCWr = 1'b1;
        st_d = DECODE;
      end
      DECODE: begin
        unique case (1'b1)
          is_j: begin
            PCWr  = 1'b1;
            NPCOp = 2'b10;
          end
          is_jal: begin
            PCWr  = 1'b1;
            NPCOp = 2'b10;
            RegWr = 1'b1;
          end
          is_jr: begin
            PCWr  = 1'b1;
            NPCOp = 2'b11;
          end
          is_addu, is_subu, is_ori, is_lw,
          is_sw, is_beq, is_lui: st_d = EXE;
          default: st_d = FETCH;
        endcase
      end
      EXE: begin
        unique case (1'b1)
          is_beq: begin
            PCWr  = zero;
            NPCOp = 2'b01;
          end
          is_lw:   st_d = MEM_RD;
          is_sw:   st_d = MEM_WR;
          default: st_d = WB;
        endcase
      end
      MEM_RD: st_d = WB;
      MEM_WR: MemWr = 1'b1;
      WB:     RegWr = 1'b1;
      default: st_d = FETCH;
    endcase
    // Held reset abandons the instruction: no write may land.
    if (!reset) begin
      PCWr  = 1'b0;
      IRWr  = 1'b0;
      RegWr = 1'b0;
      MemWr = 1'b0;
    end
  end

endmodule
